// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants for the cache miss/fill path: geometry, address fields,
// FSM encoding and a block-alignment helper.
package cache_fill_fsm_pkg;

    localparam int ADDR_W   = 16;  // byte address
    localparam int WORDS    = 8;   // 16-bit words per block
    localparam int NUM_SETS = 64;
    localparam int TAG_W    = 6;
    localparam int SET_W    = 6;
    localparam int OFFSET_W = 3;   // word offset within block
    localparam int CNT_W    = 4;   // counters must be able to hold WORDS itself

    // Address layout: [15:10] tag, [9:4] set, [3:1] word, [0] byte
    localparam int BLK_LSB  = OFFSET_W + 1;
    localparam int TAG_LSB  = ADDR_W - TAG_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_TAG  = 2'd2;

    // First byte of the block containing addr.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'((1 << BLK_LSB) - 1);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Small up-counter used for both the request and the return side of a fill.
// Stops at MAX so a stray enable after the last word can never wrap it.
module fill_counter #(
    parameter int CNT_W = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Saturating count with synchronous clear
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count < CNT_W'(MAX))) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: on a miss, requests the 8 words of the block one per
// cycle, streams returned words into the data array, then writes {valid,tag}
// into the metadata array for one cycle. fsm_busy stalls the pipeline
// throughout.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_detected,
    input  logic [ADDR_W-1:0]   miss_address,
    input  logic                memory_data_valid,
    input  logic [15:0]         memory_data,
    output logic                fsm_busy,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   memory_address,
    output logic                write_data_array,
    output logic [OFFSET_W-1:0] fill_word_idx,
    output logic [15:0]         fill_data,
    output logic                write_tag_array,
    output logic [TAG_W:0]      tag_out,
    output logic [NUM_SETS-1:0] set_enable
);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              in_fill;
    logic              word_in;
    logic              last_word;

    assign in_fill   = (state == ST_FILL);
    // Returns outside FILL (idle, tag cycle, after a reset) are dropped here
    assign word_in   = in_fill && memory_data_valid;
    assign last_word = word_in && (recv_cnt == CNT_W'(WORDS - 1));

    // Counters are held at zero whenever no fill is running, so every fill
    // starts from word 0 without an explicit load.
    fill_counter #(.CNT_W(CNT_W), .MAX(WORDS)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!in_fill),
        .en    (in_fill),
        .count (issue_cnt)
    );

    fill_counter #(.CNT_W(CNT_W), .MAX(WORDS)) u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!in_fill),
        .en    (word_in),
        .count (recv_cnt)
    );

    // Next-state decode; a miss is only taken from IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (miss_detected) state_next = ST_FILL;
            ST_FILL: if (last_word)     state_next = ST_TAG;
            ST_TAG:                     state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // State and latched block base; base only moves on miss acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            base  <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_IDLE) && miss_detected) begin
                base <= block_base(miss_address);
            end
        end
    end

    // Output decode from registered state; only the data-write strobe and
    // the data itself follow the memory inputs combinationally.
    always_comb begin
        fsm_busy         = (state != ST_IDLE);
        mem_en           = in_fill && (issue_cnt < CNT_W'(WORDS));
        memory_address   = mem_en ? (base + ADDR_W'({issue_cnt, 1'b0})) : '0;
        write_data_array = word_in;
        fill_word_idx    = in_fill ? recv_cnt[OFFSET_W-1:0] : '0;
        fill_data        = memory_data;
        write_tag_array  = (state == ST_TAG);
        tag_out          = (state == ST_TAG) ? {1'b1, base[TAG_LSB +: TAG_W]} : '0;
        set_enable       = fsm_busy ? (NUM_SETS'(1) << base[BLK_LSB +: SET_W]) : '0;
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a latency-programmable memory model answers the
// DUT's requests, a scoreboard holds the expected requests, data writes and
// tag writes queued when each miss is presented, and a monitor pops them as
// the DUT produces them.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = '0;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word_idx;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic [6:0]  tag_out;
    logic [63:0] set_enable;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_en            (mem_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_idx     (fill_word_idx),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array),
        .tag_out           (tag_out),
        .set_enable        (set_enable)
    );

    typedef struct { int due; logic [15:0] addr; } pend_t;
    typedef struct { logic [2:0] idx; logic [15:0] data; } wr_t;
    typedef struct { logic [6:0] tag; logic [63:0] set; } tag_t;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int lat    = 4;
    bit spur   = 1'b0;

    pend_t       pend[$];
    logic [15:0] exp_req[$];
    wr_t         exp_wr[$];
    tag_t        exp_tag[$];

    int          req_n = 0, wr_n = 0, tag_n = 0, last_wr_cyc = 0, tag_cyc = 0;
    logic [6:0]  last_tag = '0;
    logic [63:0] last_set = '0;

    // Distinct word per address so misplaced data is visible
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], ~a[15:8]};
    endfunction

    always @(posedge clk) cyc++;

    // Memory: a request seen in cycle c is answered in cycle c+lat, in order
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            pend_t p;
            p.due  = cyc + lat;
            p.addr = memory_address;
            pend.push_back(p);
        end
    end

    always @(posedge clk) begin
        #2;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else if (spur) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'hDEAD;
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = '0;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [15:0] er;
        wr_t         ew;
        tag_t        et;
        if (mem_en === 1'b1) begin
            req_n++;
            checks++;
            if (exp_req.size() == 0) begin
                $display("FAIL req_unexpected: got addr %h, no request expected", memory_address);
            end else begin
                er = exp_req.pop_front();
                if (memory_address !== er)
                    $display("FAIL req_addr: got %h want %h", memory_address, er);
                else passes++;
            end
        end
        if (write_data_array === 1'b1) begin
            wr_n++;
            last_wr_cyc = cyc;
            checks++;
            if (exp_wr.size() == 0) begin
                $display("FAIL wr_unexpected: got idx %0d data %h, no write expected", fill_word_idx, fill_data);
            end else begin
                ew = exp_wr.pop_front();
                if (fill_word_idx !== ew.idx || fill_data !== ew.data)
                    $display("FAIL wr_word: got idx %0d data %h want idx %0d data %h",
                             fill_word_idx, fill_data, ew.idx, ew.data);
                else passes++;
            end
        end
        if (write_tag_array === 1'b1) begin
            tag_n++;
            tag_cyc  = cyc;
            last_tag = tag_out;
            last_set = set_enable;
            checks++;
            if (exp_tag.size() == 0) begin
                $display("FAIL tag_unexpected: got tag %b set %h", tag_out, set_enable);
            end else begin
                et = exp_tag.pop_front();
                if (tag_out !== et.tag || set_enable !== et.set)
                    $display("FAIL tag_write: got tag %b set %h want tag %b set %h",
                             tag_out, set_enable, et.tag, et.set);
                else passes++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Queue everything a complete fill of addr's block should produce
    task automatic push_fill(input logic [15:0] addr);
        logic [15:0] b;
        wr_t  w;
        tag_t t;
        b = addr & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
            exp_req.push_back(b + 16'(2 * i));
            w.idx  = 3'(i);
            w.data = mem_word(b + 16'(2 * i));
            exp_wr.push_back(w);
        end
        t.tag = 7'h40 | 7'(b >> 10);
        t.set = 64'd1 << ((b >> 4) & 16'h3F);
        exp_tag.push_back(t);
    endtask

    // Present a miss for one cycle, then count cycles with fsm_busy high
    task automatic run_miss(input logic [15:0] addr, output int busy_n);
        tick;
        miss_detected = 1'b1;
        miss_address  = addr;
        push_fill(addr);
        @(negedge clk);
        tick;
        miss_detected = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (fsm_busy !== 1'b1) break;
            busy_n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick;
        @(negedge clk);
        checks++; if (fsm_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", fsm_busy); else passes++;
        checks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en); else passes++;
        checks++; if (memory_address !== 16'h0) $display("FAIL reset_addr: got %h want 0", memory_address); else passes++;
        checks++; if (write_data_array !== 1'b0) $display("FAIL reset_wda: got %b want 0", write_data_array); else passes++;
        checks++; if (fill_word_idx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", fill_word_idx); else passes++;
        checks++; if (write_tag_array !== 1'b0) $display("FAIL reset_wta: got %b want 0", write_tag_array); else passes++;
        checks++; if (tag_out !== 7'd0) $display("FAIL reset_tag: got %b want 0", tag_out); else passes++;
        checks++; if (set_enable !== 64'd0) $display("FAIL reset_set: got %h want 0", set_enable); else passes++;
        tick;
        rst = 1'b0;
    endtask

    // Busy low again in cycle 8+L+2 counting the miss cycle as 0: 9+L busy cycles
    task automatic test_basic_fill;
        int bn, w0, t0;
        lat = 4;
        w0 = wr_n; t0 = tag_n;
        run_miss(16'h1234, bn);
        checks++; if (bn !== 13) $display("FAIL basic_busy_cycles: got %0d want 13", bn); else passes++;
        checks++; if (wr_n - w0 !== 8) $display("FAIL basic_writes: got %0d want 8", wr_n - w0); else passes++;
        checks++; if (tag_n - t0 !== 1) $display("FAIL basic_tag_count: got %0d want 1", tag_n - t0); else passes++;
        checks++; if (last_tag !== 7'b1_000100) $display("FAIL basic_tag: got %b want 1000100", last_tag); else passes++;
        checks++; if (last_set !== (64'd1 << 35)) $display("FAIL basic_set: got %h want bit 35", last_set); else passes++;
    endtask

    task automatic test_latency1;
        int bn, w0;
        lat = 1;
        w0 = wr_n;
        run_miss(16'h8A5E, bn);
        checks++; if (bn !== 10) $display("FAIL lat1_busy_cycles: got %0d want 10", bn); else passes++;
        checks++; if (wr_n - w0 !== 8) $display("FAIL lat1_writes: got %0d want 8", wr_n - w0); else passes++;
        checks++; if (tag_cyc !== last_wr_cyc + 1)
            $display("FAIL lat1_tag_after_last_word: got cycle %0d want %0d", tag_cyc, last_wr_cyc + 1);
        else passes++;
    endtask

    // New miss held from mid-fill through the tag cycle must be ignored
    task automatic test_miss_while_busy;
        bit seen_tag;
        int t0;
        lat = 3;
        t0 = tag_n;
        seen_tag = 1'b0;
        tick;
        miss_detected = 1'b1;
        miss_address  = 16'h1234;
        push_fill(16'h1234);
        @(negedge clk);
        tick;
        miss_detected = 1'b0;
        for (int k = 0; k < 200 && !seen_tag; k++) begin
            @(negedge clk);
            if (write_tag_array === 1'b1) seen_tag = 1'b1;
            tick;
            if (k == 2) begin
                miss_detected = 1'b1;
                miss_address  = 16'hFFF0;
            end
        end
        miss_detected = 1'b0;
        @(negedge clk);
        checks++; if (!seen_tag) $display("FAIL busy_miss_tag_seen: got no tag write want one"); else passes++;
        checks++; if (fsm_busy !== 1'b0) $display("FAIL busy_miss_not_taken: got busy %b want 0", fsm_busy); else passes++;
        checks++; if (tag_n - t0 !== 1) $display("FAIL busy_miss_tag_count: got %0d want 1", tag_n - t0); else passes++;
        checks++; if (last_tag !== 7'b1_000100 || last_set !== (64'd1 << 35))
            $display("FAIL busy_miss_tag: got tag %b set %h want 1000100 bit 35", last_tag, last_set);
        else passes++;
    endtask

    task automatic test_spurious_valid;
        int bn;
        tick;
        spur = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            @(negedge clk);
            checks++;
            if (write_data_array !== 1'b0 || fsm_busy !== 1'b0 || mem_en !== 1'b0 || fill_word_idx !== 3'd0)
                $display("FAIL spurious_idle: got wda %b busy %b mem_en %b idx %0d want all 0",
                         write_data_array, fsm_busy, mem_en, fill_word_idx);
            else passes++;
        end
        tick;
        spur = 1'b0;
        // Following fill must still begin at word 0 (checked by the scoreboard)
        lat = 2;
        run_miss(16'h2468, bn);
        checks++; if (bn !== 11) $display("FAIL spurious_fill_busy: got %0d want 11", bn); else passes++;
    endtask

    task automatic test_reset_mid_fill;
        int got, wn, bn;
        lat = 4;
        got = 0;
        tick;
        miss_detected = 1'b1;
        miss_address  = 16'h5678;
        push_fill(16'h5678);
        @(negedge clk);
        tick;
        miss_detected = 1'b0;
        for (int k = 0; k < 100 && got < 3; k++) begin
            @(negedge clk);
            if (write_data_array === 1'b1) got++;
            if (got < 3) tick;
        end
        checks++; if (got !== 3) $display("FAIL rstmid_three_words: got %0d want 3", got); else passes++;
        tick;
        rst = 1'b1;
        @(negedge clk);
        tick;
        rst = 1'b0;
        exp_req.delete();
        exp_wr.delete();
        exp_tag.delete();
        wn = wr_n;
        @(negedge clk);
        checks++;
        if (fsm_busy !== 1'b0 || mem_en !== 1'b0 || memory_address !== 16'h0 || write_data_array !== 1'b0 ||
            fill_word_idx !== 3'd0 || write_tag_array !== 1'b0 || tag_out !== 7'd0 || set_enable !== 64'd0)
            $display("FAIL rstmid_outputs: got busy %b mem_en %b addr %h wda %b idx %0d wta %b tag %b set %h want all 0",
                     fsm_busy, mem_en, memory_address, write_data_array, fill_word_idx,
                     write_tag_array, tag_out, set_enable);
        else passes++;
        for (int k = 0; k < 50 && pend.size() > 0; k++) tick;
        repeat (2) tick;
        @(negedge clk);
        checks++; if (wr_n !== wn) $display("FAIL rstmid_late_returns: got %0d writes want 0", wr_n - wn); else passes++;
        run_miss(16'h0000, bn);
        checks++; if (bn !== 13) $display("FAIL rstmid_refill_busy: got %0d want 13", bn); else passes++;
        checks++; if (last_tag !== 7'b1_000000 || last_set !== 64'd1)
            $display("FAIL rstmid_refill_tag: got tag %b set %h want 1000000 1", last_tag, last_set);
        else passes++;
    endtask

    task automatic test_back_to_back;
        int b1, b2, t0;
        lat = 2;
        t0 = tag_n;
        run_miss(16'h0010, b1);
        checks++; if (b1 !== 11) $display("FAIL b2b_first_busy: got %0d want 11", b1); else passes++;
        checks++; if (last_tag !== 7'b1_000000 || last_set !== 64'd2)
            $display("FAIL b2b_first_tag: got tag %b set %h want 1000000 2", last_tag, last_set);
        else passes++;
        run_miss(16'h0410, b2);
        checks++; if (b2 !== 11) $display("FAIL b2b_second_busy: got %0d want 11", b2); else passes++;
        checks++; if (last_tag !== 7'b1_000001 || last_set !== 64'd2)
            $display("FAIL b2b_second_tag: got tag %b set %h want 1000001 2", last_tag, last_set);
        else passes++;
        checks++; if (tag_n - t0 !== 2) $display("FAIL b2b_tag_count: got %0d want 2", tag_n - t0); else passes++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic_fill;
        test_latency1;
        test_miss_while_busy;
        test_spurious_valid;
        test_reset_mid_fill;
        test_back_to_back;
        repeat (3) tick;
        checks++; if (exp_req.size() != 0) $display("FAIL leftover_requests: got %0d want 0", exp_req.size()); else passes++;
        checks++; if (exp_wr.size() != 0) $display("FAIL leftover_writes: got %0d want 0", exp_wr.size()); else passes++;
        checks++; if (exp_tag.size() != 0) $display("FAIL leftover_tags: got %0d want 0", exp_tag.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
